ahb_sram_ctrl: RTL and testbench

AHB-Lite slave that acts as the initiator for four 8-bit `sram_8_8192_scn4m_subm` byte-lane macros, presenting them as one 32 KiB, 32-bit-wide, zero-wait-state memory. It registers the AHB address phase and drives the macro pins during the data phase. It generates per-lane chip selects for byte, halfword and word writes. It returns a two-cycle ERROR response for transfers the memory cannot serve. It sits between the AHB interconnect/decoder and the SRAM macros, which are clocked by the same HCLK.

---
 rtl/ahb_sram_pkg.sv | 32 +++
 rtl/ahb_sram_ctrl_if.sv | 32 +++
 rtl/ahb_sram_lane_dec.sv | 47 ++++
 rtl/ahb_sram_ctrl.sv | 114 +++++++++++
 tb/tb_ahb_sram_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_sram_pkg
//  Purpose  : Shared AHB encodings, FSM state type and lane count for the
//             AHB-Lite to SRAM-macro controller.
//  Revision : 1.0  initial release
// ============================================================================
package ahb_sram_pkg;

    localparam logic [1:0] c_HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] c_HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] c_HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] c_HSIZE_BYTE = 3'd0;
    localparam logic [2:0] c_HSIZE_HALF = 3'd1;
    localparam logic [2:0] c_HSIZE_WORD = 3'd2;

    localparam logic c_HRESP_OKAY  = 1'b0;
    localparam logic c_HRESP_ERROR = 1'b1;

    localparam int c_NUM_LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ERR1   = 2'd2,
        ST_ERR2   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ahb_sram_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_sram_ctrl_if
//  Purpose  : AHB-Lite slave-port bundle with master/slave views.
//  Revision : 1.0  initial release
// ============================================================================
interface ahb_sram_ctrl_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );

endinterface
`default_nettype wire

// File: rtl/ahb_sram_lane_dec.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_sram_lane_dec
//  Purpose  : Maps transfer size/alignment/direction to active-low byte-lane
//             selects and flags transfers the memory cannot serve.
//  Revision : 1.0  initial release
// ============================================================================
module ahb_sram_lane_dec
    import ahb_sram_pkg::*;
(
    input  logic [2:0]             i_hsize,
    input  logic [1:0]             i_addr_lo,
    input  logic                   i_hwrite,
    output logic [c_NUM_LANES-1:0] o_lane_csb,
    output logic                   o_illegal
);

    logic [c_NUM_LANES-1:0] w_byte_sel;
    logic [c_NUM_LANES-1:0] w_we_mask;

    generate
        for (genvar gi = 0; gi < c_NUM_LANES; gi++) begin : g_lane
            assign w_byte_sel[gi] = (i_addr_lo == 2'(gi));
        end
    endgenerate

    always_comb begin
        o_illegal = 1'b0;
        w_we_mask = '0;
        case (i_hsize)
            c_HSIZE_BYTE: w_we_mask = w_byte_sel;
            c_HSIZE_HALF: begin
                o_illegal = i_addr_lo[0];
                w_we_mask = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            c_HSIZE_WORD: begin
                o_illegal = |i_addr_lo;
                w_we_mask = '1;
            end
            default: o_illegal = 1'b1;
        endcase
        // Reads always fetch the whole word; the master picks its lanes.
        o_lane_csb = i_hwrite ? ~w_we_mask : '0;
    end

endmodule
`default_nettype wire

// File: rtl/ahb_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_sram_ctrl
//  Purpose  : Zero-wait-state AHB-Lite slave driving four 8-bit SRAM macros
//             as one 32-bit memory, with two-cycle ERROR for bad transfers.
//  Revision : 1.0  initial release
// ============================================================================
module ahb_sram_ctrl
    import ahb_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int NUM_LANES  = c_NUM_LANES
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    ahb_sram_ctrl_if.slave         ahb,
    output logic [NUM_LANES-1:0]   sram_csb,
    output logic                   sram_web,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [8*NUM_LANES-1:0] sram_din,
    input  logic [8*NUM_LANES-1:0] sram_dout
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic                   r_write;
    logic [NUM_LANES-1:0]   r_lane_csb;
    logic [31:0]            r_din_last;
    logic                   r_hreadyout;
    logic                   r_hresp;
    logic                   w_ready_nxt;
    logic                   w_resp_nxt;
    logic                   w_accept;
    logic                   w_illegal;
    logic [NUM_LANES-1:0]   w_lane_csb;
    logic                   w_access;
    logic                   w_unused_ok;

    assign w_unused_ok = &{1'b0, ahb.HBURST, ahb.HADDR[31:ADDR_WIDTH+2], ahb.HTRANS[0]};

    // HREADY is low in ERR1, so nothing can be sampled there anyway.
    assign w_accept = ahb.HSEL && ahb.HREADY && ahb.HTRANS[1] && (r_state != ST_ERR1);
    assign w_access = (r_state == ST_ACCESS);

    ahb_sram_lane_dec u_lane_dec (
        .i_hsize    (ahb.HSIZE),
        .i_addr_lo  (ahb.HADDR[1:0]),
        .i_hwrite   (ahb.HWRITE),
        .o_lane_csb (w_lane_csb),
        .o_illegal  (w_illegal)
    );

    always_comb begin
        w_state_nxt = ST_IDLE;
        w_ready_nxt = 1'b1;
        w_resp_nxt  = c_HRESP_OKAY;
        case (r_state)
            ST_ERR1: w_state_nxt = ST_ERR2;
            default: begin
                if (w_accept) begin
                    w_state_nxt = w_illegal ? ST_ERR1 : ST_ACCESS;
                end
            end
        endcase
        // Response flops are loaded from the next state so they line up
        // with the cycle that state occupies.
        case (w_state_nxt)
            ST_ERR1: begin
                w_ready_nxt = 1'b0;
                w_resp_nxt  = c_HRESP_ERROR;
            end
            ST_ERR2: w_resp_nxt = c_HRESP_ERROR;
            default: ;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_lane_csb  <= '1;
            r_din_last  <= '0;
            r_hreadyout <= 1'b1;
            r_hresp     <= c_HRESP_OKAY;
        end else begin
            r_state     <= w_state_nxt;
            r_hreadyout <= w_ready_nxt;
            r_hresp     <= w_resp_nxt;
            if (w_accept && !w_illegal) begin
                r_addr     <= ahb.HADDR[ADDR_WIDTH+1:2];
                r_write    <= ahb.HWRITE;
                r_lane_csb <= w_lane_csb;
            end
            if (w_access) begin
                r_din_last <= ahb.HWDATA;
            end
        end
    end

    always_comb begin
        sram_csb   = w_access ? r_lane_csb : '1;
        sram_web   = w_access ? !r_write : 1'b1;
        sram_addr  = r_addr;
        sram_din   = w_access ? ahb.HWDATA : r_din_last;
        ahb.HRDATA = (w_access && r_write == 1'b0) ? sram_dout : 32'h0;
    end

    assign ahb.HREADYOUT = r_hreadyout;
    assign ahb.HRESP     = r_hresp;

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_sram_ctrl
//  Purpose  : Directed self-checking bench for ahb_sram_ctrl with a
//             falling-edge SRAM macro model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ahb_sram_ctrl;
    import ahb_sram_pkg::*;

    logic        HCLK;
    logic        HRESETn;
    logic [3:0]  sram_csb;
    logic        sram_web;
    logic [12:0] sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;

    int checks   = 0;
    int failures = 0;

    ahb_sram_ctrl_if bus ();

    assign bus.HREADY = bus.HREADYOUT;

    ahb_sram_ctrl #(.ADDR_WIDTH(13), .NUM_LANES(4)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .ahb       (bus),
        .sram_csb  (sram_csb),
        .sram_web  (sram_web),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Four byte-lane macros sampling their pins on the falling edge.
    logic [7:0] mem [4][8192];

    always @(negedge HCLK) begin
        for (int l = 0; l < 4; l++) begin
            if (!sram_csb[l]) begin
                if (!sram_web) mem[l][sram_addr] <= sram_din[8*l +: 8];
                else           sram_dout[8*l +: 8] <= mem[l][sram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic settle();
        #6;
    endtask

    task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [2:0] size, input logic [31:0] addr);
        bus.HSEL   = sel;
        bus.HTRANS = trans;
        bus.HWRITE = wr;
        bus.HSIZE  = size;
        bus.HADDR  = addr;
    endtask

    task automatic idle();
        drive(1'b1, c_HTRANS_IDLE, 1'b0, c_HSIZE_WORD, 32'h0);
    endtask

    initial begin
        for (int l = 0; l < 4; l++)
            for (int a = 0; a < 8192; a++) mem[l][a] = 8'h00;
        sram_dout  = 32'h0;
        HRESETn    = 1'b0;
        bus.HBURST = 3'd0;
        bus.HWDATA = 32'h0;
        idle();
        step();
        step();

        // Reset values.
        chk("rst_hreadyout", {31'd0, bus.HREADYOUT}, 32'd1);
        chk("rst_hresp",     {31'd0, bus.HRESP},     32'd0);
        chk("rst_hrdata",    bus.HRDATA,             32'h0);
        chk("rst_csb",       {28'd0, sram_csb},      32'hF);
        chk("rst_web",       {31'd0, sram_web},      32'd1);
        chk("rst_addr",      {19'd0, sram_addr},     32'h0);
        HRESETn = 1'b1;
        step();

        // Reset asserted in the data phase of a word write to 0x200.
        drive(1'b1, c_HTRANS_NONSEQ, 1'b1, c_HSIZE_WORD, 32'h0000_0200);
        step();
        bus.HWDATA = 32'hCAFE_F00D;
        idle();
        #1;
        chk("midwr_csb_active", {28'd0, sram_csb}, 32'h0);
        HRESETn = 1'b0;
        #1;
        chk("midrst_csb",       {28'd0, sram_csb},      32'hF);
        chk("midrst_web",       {31'd0, sram_web},      32'd1);
        chk("midrst_addr",      {19'd0, sram_addr},     32'h0);
        chk("midrst_hreadyout", {31'd0, bus.HREADYOUT}, 32'd1);
        chk("midrst_hresp",     {31'd0, bus.HRESP},     32'd0);
        chk("midrst_hrdata",    bus.HRDATA,             32'h0);
        step();
        HRESETn = 1'b1;
        step();

        // Word round trip at 0x100.
        drive(1'b1, c_HTRANS_NONSEQ, 1'b1, c_HSIZE_WORD, 32'h0000_0100);
        step();
        bus.HWDATA = 32'hDEAD_BEEF;
        drive(1'b1, c_HTRANS_NONSEQ, 1'b0, c_HSIZE_WORD, 32'h0000_0100);
        settle();
        chk("w100_csb",   {28'd0, sram_csb},      32'h0);
        chk("w100_web",   {31'd0, sram_web},      32'd0);
        chk("w100_addr",  {19'd0, sram_addr},     32'h40);
        chk("w100_ready", {31'd0, bus.HREADYOUT}, 32'd1);
        step();
        idle();
        settle();
        chk("r100_web",    {31'd0, sram_web},      32'd1);
        chk("r100_csb",    {28'd0, sram_csb},      32'h0);
        chk("r100_hrdata", bus.HRDATA,             32'hDEAD_BEEF);
        chk("r100_ready",  {31'd0, bus.HREADYOUT}, 32'd1);
        step();

        // Byte-lane isolation at 0x40/0x42, then a halfword at 0x40.
        drive(1'b1, c_HTRANS_NONSEQ, 1'b1, c_HSIZE_WORD, 32'h0000_0040);
        step();
        bus.HWDATA = 32'h1122_3344;
        drive(1'b1, c_HTRANS_NONSEQ, 1'b1, c_HSIZE_BYTE, 32'h0000_0042);
        step();
        bus.HWDATA = 32'hFFAA_FFFF;
        drive(1'b1, c_HTRANS_NONSEQ, 1'b0, c_HSIZE_WORD, 32'h0000_0040);
        settle();
        chk("b42_csb", {28'd0, sram_csb}, 32'b1011);
        chk("b42_web", {31'd0, sram_web}, 32'd0);
        step();
        idle();
        settle();
        chk("r40_after_byte", bus.HRDATA, 32'h11AA_3344);
        step();
        drive(1'b1, c_HTRANS_NONSEQ, 1'b1, c_HSIZE_HALF, 32'h0000_0040);
        step();
        bus.HWDATA = 32'h9999_5678;
        drive(1'b1, c_HTRANS_NONSEQ, 1'b0, c_HSIZE_WORD, 32'h0000_0040);
        settle();
        chk("h40_csb", {28'd0, sram_csb}, 32'b1100);
        step();
        idle();
        settle();
        chk("r40_after_half", bus.HRDATA, 32'h11AA_5678);
        step();

        // Back-to-back write then read of 0x8.
        drive(1'b1, c_HTRANS_NONSEQ, 1'b1, c_HSIZE_WORD, 32'h0000_0008);
        step();
        bus.HWDATA = 32'h5A5A_5A5A;
        drive(1'b1, c_HTRANS_SEQ, 1'b0, c_HSIZE_WORD, 32'h0000_0008);
        step();
        idle();
        settle();
        chk("b2b_hrdata", bus.HRDATA,             32'h5A5A_5A5A);
        chk("b2b_ready",  {31'd0, bus.HREADYOUT}, 32'd1);
        step();

        // Misaligned word read at 0x6, followed by a legal read in ERR2.
        drive(1'b1, c_HTRANS_NONSEQ, 1'b0, c_HSIZE_WORD, 32'h0000_0006);
        step();
        idle();
        settle();
        chk("err1_ready", {31'd0, bus.HREADYOUT}, 32'd0);
        chk("err1_resp",  {31'd0, bus.HRESP},     32'd1);
        chk("err1_csb",   {28'd0, sram_csb},      32'hF);
        step();
        drive(1'b1, c_HTRANS_NONSEQ, 1'b0, c_HSIZE_WORD, 32'h0000_0100);
        settle();
        chk("err2_ready", {31'd0, bus.HREADYOUT}, 32'd1);
        chk("err2_resp",  {31'd0, bus.HRESP},     32'd1);
        chk("err2_csb",   {28'd0, sram_csb},      32'hF);
        step();
        idle();
        settle();
        chk("posterr_resp",   {31'd0, bus.HRESP},     32'd0);
        chk("posterr_ready",  {31'd0, bus.HREADYOUT}, 32'd1);
        chk("posterr_hrdata", bus.HRDATA,             32'hDEAD_BEEF);
        step();

        // Misaligned halfword at 0x41 also errors.
        drive(1'b1, c_HTRANS_NONSEQ, 1'b1, c_HSIZE_HALF, 32'h0000_0041);
        step();
        idle();
        settle();
        chk("herr_resp", {31'd0, bus.HRESP},    32'd1);
        chk("herr_csb",  {28'd0, sram_csb},     32'hF);
        step();
        step();

        // BUSY, unselected and IDLE cycles around a legal read of 0x200.
        drive(1'b1, c_HTRANS_BUSY, 1'b1, c_HSIZE_WORD, 32'h0000_0008);
        step();
        drive(1'b0, c_HTRANS_NONSEQ, 1'b1, c_HSIZE_WORD, 32'h0000_0008);
        settle();
        chk("busy_csb",  {28'd0, sram_csb},      32'hF);
        chk("busy_resp", {31'd0, bus.HRESP},     32'd0);
        step();
        idle();
        bus.HWDATA = 32'h0BAD_0BAD;
        settle();
        chk("unsel_csb",   {28'd0, sram_csb},      32'hF);
        chk("unsel_web",   {31'd0, sram_web},      32'd1);
        chk("unsel_ready", {31'd0, bus.HREADYOUT}, 32'd1);
        step();
        drive(1'b1, c_HTRANS_NONSEQ, 1'b0, c_HSIZE_WORD, 32'h0000_0200);
        settle();
        chk("idle_csb", {28'd0, sram_csb}, 32'hF);
        step();
        idle();
        settle();
        chk("r200_untouched", bus.HRDATA, 32'h0);
        step();
        drive(1'b1, c_HTRANS_NONSEQ, 1'b0, c_HSIZE_WORD, 32'h0000_0008);
        step();
        idle();
        settle();
        chk("r8_unchanged", bus.HRDATA, 32'h5A5A_5A5A);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
